equ1_2: RTL and testbench



---
 rtl/equ1_2.sv | 107 ++++++++++
 tb/tb_equ1_2.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/equ1_2.sv
`default_nettype none
// ============================================================================
//  Module   : equ1_2
//  Purpose  : Gradient/energy stage of the CFA demosaicing datapath.
//             Stage 1 captures the five row sums of a 5x5 window of 12-bit
//             unsigned pixels when start is high. Stage 2 forms, on every
//             edge, the sum of absolute differences between adjacent row
//             sums. The result feeds the direction-selection logic.
//  Ports    : clk            rising-edge clock
//             rst            asynchronous, active-high reset
//             start          capture enable for the window
//             e1t1..e5t5     window taps, row k = ek, 12-bit unsigned
//             e1..e5         registered row sums, 15-bit (1-cycle latency)
//             grad_out       registered gradient magnitude, 17-bit
//                            (2-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module equ1_2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] e1t1, e1t2, e1t3, e1t4, e1t5,
    input  logic [11:0] e2t1, e2t2, e2t3, e2t4, e2t5,
    input  logic [11:0] e3t1, e3t2, e3t3, e3t4, e3t5,
    input  logic [11:0] e4t1, e4t2, e4t3, e4t4, e4t5,
    input  logic [11:0] e5t1, e5t2, e5t3, e5t4, e5t5,
    output logic [14:0] e1,
    output logic [14:0] e2,
    output logic [14:0] e3,
    output logic [14:0] e4,
    output logic [14:0] e5,
    output logic [16:0] grad_out
);

    localparam int c_PIX_W  = 12;
    localparam int c_SUM_W  = 15;
    localparam int c_GRAD_W = 17;

    // Five 12-bit taps summed into 15 bits; 5*4095 = 20475 fits.
    function automatic logic [c_SUM_W-1:0] row_sum(
        input logic [c_PIX_W-1:0] a,
        input logic [c_PIX_W-1:0] b,
        input logic [c_PIX_W-1:0] c,
        input logic [c_PIX_W-1:0] d,
        input logic [c_PIX_W-1:0] e
    );
        return {3'b000, a} + {3'b000, b} + {3'b000, c}
             + {3'b000, d} + {3'b000, e};
    endfunction

    // Compare-and-subtract: avoids a signed intermediate entirely.
    function automatic logic [c_SUM_W-1:0] abs_diff(
        input logic [c_SUM_W-1:0] a,
        input logic [c_SUM_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [c_SUM_W-1:0]  w_sum1, w_sum2, w_sum3, w_sum4, w_sum5;
    logic [c_GRAD_W-1:0] w_grad;

    logic [c_SUM_W-1:0]  r_e1, r_e2, r_e3, r_e4, r_e5;
    logic [c_GRAD_W-1:0] r_grad;

    assign w_sum1 = row_sum(e1t1, e1t2, e1t3, e1t4, e1t5);
    assign w_sum2 = row_sum(e2t1, e2t2, e2t3, e2t4, e2t5);
    assign w_sum3 = row_sum(e3t1, e3t2, e3t3, e3t4, e3t5);
    assign w_sum4 = row_sum(e4t1, e4t2, e4t3, e4t4, e4t5);
    assign w_sum5 = row_sum(e5t1, e5t2, e5t3, e5t4, e5t5);

    // Gradient is taken from the stage-1 registers, never from the inputs,
    // so there is no input-to-output combinational path.
    assign w_grad = {2'b00, abs_diff(r_e1, r_e2)}
                  + {2'b00, abs_diff(r_e2, r_e3)}
                  + {2'b00, abs_diff(r_e3, r_e4)}
                  + {2'b00, abs_diff(r_e4, r_e5)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e1   <= '0;
            r_e2   <= '0;
            r_e3   <= '0;
            r_e4   <= '0;
            r_e5   <= '0;
            r_grad <= '0;
        end else begin
            // An unknown start falls to the hold branch in simulation.
            if (start) begin
                r_e1 <= w_sum1;
                r_e2 <= w_sum2;
                r_e3 <= w_sum3;
                r_e4 <= w_sum4;
                r_e5 <= w_sum5;
            end
            r_grad <= w_grad;
        end
    end

    assign e1       = r_e1;
    assign e2       = r_e2;
    assign e3       = r_e3;
    assign e4       = r_e4;
    assign e5       = r_e5;
    assign grad_out = r_grad;

endmodule
`default_nettype wire

// File: tb/tb_equ1_2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_equ1_2
//  Purpose  : Self-checking bench for equ1_2: directed windows (flat, ramp,
//             max contrast, hold, reset) plus randomized streaming compared
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_equ1_2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] t [5][5];
    logic [14:0] e1, e2, e3, e4, e5;
    logic [16:0] grad_out;

    int checks = 0;
    int errors = 0;

    // Reference state: expected row sums and gradient after the last edge.
    int exp_e [5];
    int exp_g;

    equ1_2 dut (
        .clk(clk), .rst(rst), .start(start),
        .e1t1(t[0][0]), .e1t2(t[0][1]), .e1t3(t[0][2]), .e1t4(t[0][3]), .e1t5(t[0][4]),
        .e2t1(t[1][0]), .e2t2(t[1][1]), .e2t3(t[1][2]), .e2t4(t[1][3]), .e2t5(t[1][4]),
        .e3t1(t[2][0]), .e3t2(t[2][1]), .e3t3(t[2][2]), .e3t4(t[2][3]), .e3t5(t[2][4]),
        .e4t1(t[3][0]), .e4t2(t[3][1]), .e4t3(t[3][2]), .e4t4(t[3][3]), .e4t5(t[3][4]),
        .e5t1(t[4][0]), .e5t2(t[4][1]), .e5t3(t[4][2]), .e5t4(t[4][3]), .e5t5(t[4][4]),
        .e1(e1), .e2(e2), .e3(e3), .e4(e4), .e5(e5),
        .grad_out(grad_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_grad(input int s0, input int s1, input int s2,
                                      input int s3, input int s4);
        return iabs(s0 - s1) + iabs(s1 - s2) + iabs(s2 - s3) + iabs(s3 - s4);
    endfunction

    task automatic cmp(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".e1"}, int'(e1), exp_e[0]);
        cmp({tag, ".e2"}, int'(e2), exp_e[1]);
        cmp({tag, ".e3"}, int'(e3), exp_e[2]);
        cmp({tag, ".e4"}, int'(e4), exp_e[3]);
        cmp({tag, ".e5"}, int'(e5), exp_e[4]);
        cmp({tag, ".grad"}, int'(grad_out), exp_g);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) exp_e[k] = 0;
        exp_g = 0;
    endtask

    // Called at a negedge with inputs already driven: advances one edge,
    // updates the model, then checks at the following negedge.
    task automatic step(input string tag);
        int g_next;
        @(posedge clk);
        g_next = model_grad(exp_e[0], exp_e[1], exp_e[2], exp_e[3], exp_e[4]);
        if (start === 1'b1) begin
            for (int k = 0; k < 5; k++) begin
                exp_e[k] = 0;
                for (int j = 0; j < 5; j++) exp_e[k] += int'(t[k][j]);
            end
        end
        exp_g = g_next;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_rows(input int r0, input int r1, input int r2,
                            input int r3, input int r4);
        int rv [5];
        rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3; rv[4] = r4;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 5; j++) t[k][j] = 12'(rv[k]);
    endtask

    task automatic set_random();
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 5; j++) t[k][j] = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        set_random();
        model_reset();

        // Reset held with random inputs and a running clock.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_random();
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        @(negedge clk);
        rst = 1'b0;

        // Flat window: all sums 500, gradient 0.
        set_rows(100, 100, 100, 100, 100);
        start = 1'b1;
        step("flat_c1");
        step("flat_c2");

        // Row ramp: 500..2500, gradient 2000.
        set_rows(100, 200, 300, 400, 500);
        step("ramp_c1");
        step("ramp_c2");

        // Max contrast: gradient 81900 needs all 17 bits.
        set_rows(4095, 0, 4095, 0, 4095);
        step("maxc_c1");
        step("maxc_c2");

        // Hold: capture ramp, then inputs go to zero with start low.
        set_rows(100, 200, 300, 400, 500);
        step("hold_cap");
        start = 1'b0;
        set_rows(0, 0, 0, 0, 0);
        step("hold_1");
        step("hold_2");
        step("hold_3");

        // Asynchronous reset asserted mid-cycle clears outputs at once.
        start = 1'b1;
        set_random();
        step("pre_async");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");

        // Release mid-stream: no capture until start is high.
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        set_random();
        step("rel_nocap");
        start = 1'b1;
        step("rel_cap1");
        start = 1'b0;
        step("rel_cap2");

        // Back-to-back random windows.
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            set_random();
            step("stream");
        end

        // Random windows with sporadic start.
        for (int i = 0; i < 30; i++) begin
            set_random();
            start = ($urandom_range(0, 3) != 0);
            step("stream_gap");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
